// File: rtl/mult_sched_pkg.sv
// Shared defaults and helpers for the round-robin multiplier scheduler.
package mult_sched_pkg;

    localparam int unsigned NREQ_DEFAULT = 2;
    localparam int unsigned W_DEFAULT    = 4;
    localparam int unsigned RES_W        = 2 * W_DEFAULT + 1;

    // Requester id width; a single requester still needs one bit.
    function automatic int unsigned idw_of(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first asserted request at or above ptr, wrapping.
module rr_arbiter
    import mult_sched_pkg::*;
#(
    parameter int unsigned NREQ = NREQ_DEFAULT,
    parameter int unsigned IDW  = idw_of(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  gnt_idx
);

    logic found;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        // Outer loop is the search distance from ptr, so the first hit wins.
        for (int k = 0; k < int'(NREQ); k++) begin
            for (int i = 0; i < int'(NREQ); i++) begin
                if (!found && req[i] && (i == (int'(ptr) + k) % int'(NREQ))) begin
                    found   = 1'b1;
                    gnt[i]  = 1'b1;
                    gnt_idx = IDW'(i);
                end
            end
        end
    end

endmodule

// File: rtl/mult_share_sched.sv
// Shares one combinational multiplier among NREQ requesters: an operand stage (S1)
// feeding the multiplier and a response stage (S2) capturing its result.
module mult_share_sched
    import mult_sched_pkg::*;
#(
    parameter int unsigned NREQ = NREQ_DEFAULT,
    parameter int unsigned W    = W_DEFAULT,
    parameter int unsigned IDW  = idw_of(NREQ)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*W-1:0] req_a,
    input  logic [NREQ*W-1:0] req_b,
    output logic [W-1:0]      mul_a,
    output logic [W-1:0]      mul_b,
    input  logic [2*W:0]      mul_res,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [IDW-1:0]    rsp_id,
    output logic [2*W-1:0]    rsp_prod,
    output logic              rsp_ovf
);

    logic [NREQ-1:0] gnt;
    logic [IDW-1:0]  gnt_idx;
    logic [W-1:0]    sel_a, sel_b;

    logic            s2_load, s1_free, xfer;

    logic            s1_v_q, s1_v_d;
    logic [IDW-1:0]  s1_id_q, s1_id_d;
    logic [W-1:0]    mul_a_q, mul_a_d;
    logic [W-1:0]    mul_b_q, mul_b_d;
    logic [IDW-1:0]  ptr_q, ptr_d;

    logic            rsp_valid_q, rsp_valid_d;
    logic [IDW-1:0]  rsp_id_q, rsp_id_d;
    logic [2*W-1:0]  rsp_prod_q, rsp_prod_d;
    logic            rsp_ovf_q, rsp_ovf_d;

    rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_arb (
        .req     (req_valid),
        .ptr     (ptr_q),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    // Stage advance: S1 moves whenever S2 is empty or draining this edge.
    always_comb begin
        s2_load = s1_v_q & (~rsp_valid_q | rsp_ready);
        s1_free = ~s1_v_q | s2_load;
        // Grants are suppressed during reset so nothing is accepted and then dropped.
        req_ready = gnt & {NREQ{s1_free & (|req_valid) & rst_n}};
        xfer      = |(req_valid & req_ready);
    end

    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < int'(NREQ); i++) begin
            if (gnt[i]) begin
                sel_a = req_a[i*W +: W];
                sel_b = req_b[i*W +: W];
            end
        end
    end

    always_comb begin
        s1_v_d  = xfer | (s1_v_q & ~s2_load);
        s1_id_d = s1_id_q;
        mul_a_d = mul_a_q;
        mul_b_d = mul_b_q;
        ptr_d   = ptr_q;
        if (xfer) begin
            s1_id_d = gnt_idx;
            mul_a_d = sel_a;
            mul_b_d = sel_b;
            ptr_d   = (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
        end
    end

    always_comb begin
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_prod_d  = rsp_prod_q;
        rsp_ovf_d   = rsp_ovf_q;
        if (s2_load) begin
            rsp_valid_d = 1'b1;
            rsp_id_d    = s1_id_q;
            rsp_prod_d  = mul_res[2*W-1:0];
            rsp_ovf_d   = mul_res[2*W];
        end else if (rsp_valid_q && rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_v_q      <= 1'b0;
            s1_id_q     <= '0;
            mul_a_q     <= '0;
            mul_b_q     <= '0;
            ptr_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_prod_q  <= '0;
            rsp_ovf_q   <= 1'b0;
        end else begin
            s1_v_q      <= s1_v_d;
            s1_id_q     <= s1_id_d;
            mul_a_q     <= mul_a_d;
            mul_b_q     <= mul_b_d;
            ptr_q       <= ptr_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_prod_q  <= rsp_prod_d;
            rsp_ovf_q   <= rsp_ovf_d;
        end
    end

    assign mul_a     = mul_a_q;
    assign mul_b     = mul_b_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_prod  = rsp_prod_q;
    assign rsp_ovf   = rsp_ovf_q;

    always_comb begin
        assert ($onehot0(req_ready));
    end

endmodule

// File: tb/tb_mult_share_sched.sv
// Bench for mult_share_sched: directed scenarios then random traffic against a
// queue-based model of a two-deep result pipeline with round-robin grants.
module tb_mult_share_sched;
    localparam int unsigned NREQ = 2;
    localparam int unsigned W    = 4;
    localparam int unsigned IDW  = 1;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NREQ-1:0]   req_valid, req_ready;
    logic [NREQ*W-1:0] req_a, req_b;
    logic [W-1:0]      mul_a, mul_b;
    logic [2*W:0]      mul_res;
    logic              rsp_valid, rsp_ready;
    logic [IDW-1:0]    rsp_id;
    logic [2*W-1:0]    rsp_prod;
    logic              rsp_ovf;
    logic              ovf_en;
    logic [2*W-1:0]    mprod;

    always #5 clk = ~clk;

    // Stand-in for multi_samp; the top bit is driven from the operands so the
    // overflow pass-through is observable.
    assign mprod   = (2*W)'(mul_a) * (2*W)'(mul_b);
    assign mul_res = {ovf_en & mul_a[W-1] & mul_b[W-1], mprod};

    mult_share_sched #(
        .NREQ (NREQ),
        .W    (W),
        .IDW  (IDW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .mul_a     (mul_a),
        .mul_b     (mul_b),
        .mul_res   (mul_res),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_prod  (rsp_prod),
        .rsp_ovf   (rsp_ovf)
    );

    typedef struct {
        int id;
        int prod;
        int ovf;
        bit shown;
    } item_t;

    item_t q[$];
    int    ptr_m, last_a, last_b;
    int    n_chk, n_pass, xfers;
    int    log_id[$];
    int    log_prod[$];
    bit    logging;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int winner();
        for (int k = 0; k < int'(NREQ); k++) begin
            if (req_valid[(ptr_m + k) % NREQ]) return (ptr_m + k) % NREQ;
        end
        return -1;
    endfunction

    task automatic cycle(input logic rn, input logic [1:0] v, input logic [3:0] a0,
                         input logic [3:0] b0, input logic [3:0] a1, input logic [3:0] b1,
                         input logic rr);
        int    w, acc, a, b;
        bit    exp_v, free;
        logic [NREQ-1:0] exp_rdy;
        item_t it;
        rst_n = rn;
        req_valid = v;
        req_a = {a1, a0};
        req_b = {b1, b0};
        rsp_ready = rr;
        @(negedge clk);
        w       = winner();
        exp_v   = (q.size() > 0) && q[0].shown;
        free    = (q.size() < 2) || (exp_v && rr);
        exp_rdy = (rn && free && w >= 0) ? NREQ'(1 << w) : '0;
        chk("req_ready", 32'(req_ready), 32'(exp_rdy));
        chk("rsp_valid", 32'(rsp_valid), 32'(exp_v));
        if (exp_v) begin
            chk("rsp_id", 32'(rsp_id), q[0].id);
            chk("rsp_prod", 32'(rsp_prod), q[0].prod);
            chk("rsp_ovf", 32'(rsp_ovf), q[0].ovf);
        end
        chk("mul_a", 32'(mul_a), last_a);
        chk("mul_b", 32'(mul_b), last_b);
        if (|(req_valid & req_ready)) xfers++;
        if (logging && rsp_valid && rr) begin
            log_id.push_back(int'(rsp_id));
            log_prod.push_back(int'(rsp_prod));
        end
        acc = (exp_rdy != '0) ? w : -1;
        @(posedge clk);
        if (!rn) begin
            q.delete();
            ptr_m  = 0;
            last_a = 0;
            last_b = 0;
        end else begin
            if (exp_v && rr) void'(q.pop_front());
            foreach (q[i]) q[i].shown = 1'b1;
            if (acc >= 0) begin
                a        = int'(req_a[acc*W +: W]);
                b        = int'(req_b[acc*W +: W]);
                it.id    = acc;
                it.prod  = a * b;
                it.ovf   = (ovf_en && a >= 8 && b >= 8) ? 1 : 0;
                it.shown = 1'b0;
                q.push_back(it);
                last_a = a;
                last_b = b;
                ptr_m  = (acc + 1) % NREQ;
            end
        end
        #1;
    endtask

    initial begin
        n_chk = 0; n_pass = 0; xfers = 0; logging = 0;
        ptr_m = 0; last_a = 0; last_b = 0;
        ovf_en = 1'b0;
        rst_n = 1'b0; req_valid = 2'b11; req_a = '0; req_b = '0; rsp_ready = 1'b0;
        @(posedge clk);
        #1;

        // Reset held with both requesters asserting.
        cycle(1'b0, 2'b11, 4'h3, 4'h2, 4'h5, 4'h3, 1'b0);
        cycle(1'b0, 2'b11, 4'h3, 4'h2, 4'h5, 4'h3, 1'b0);

        // Single requester, zero product then 15*1.
        cycle(1'b1, 2'b01, 4'h0, 4'h1, 4'h0, 4'h0, 1'b1);
        cycle(1'b1, 2'b00, 4'h0, 4'h0, 4'h0, 4'h0, 1'b1);
        cycle(1'b1, 2'b00, 4'h0, 4'h0, 4'h0, 4'h0, 1'b1);
        cycle(1'b1, 2'b01, 4'hf, 4'h1, 4'h0, 4'h0, 1'b1);
        cycle(1'b1, 2'b00, 4'h0, 4'h0, 4'h0, 4'h0, 1'b1);
        cycle(1'b1, 2'b00, 4'h0, 4'h0, 4'h0, 4'h0, 1'b1);

        // Contention: responses must alternate between 3*2 and 5*3.
        logging = 1;
        for (int i = 0; i < 8; i++) cycle(1'b1, 2'b11, 4'h3, 4'h2, 4'h5, 4'h3, 1'b1);
        cycle(1'b1, 2'b00, 4'h0, 4'h0, 4'h0, 4'h0, 1'b1);
        cycle(1'b1, 2'b00, 4'h0, 4'h0, 4'h0, 4'h0, 1'b1);
        logging = 0;
        chk("contention_count", 32'(log_id.size() >= 4), 32'd1);
        for (int i = 0; i + 1 < log_id.size() && i < 4; i++) begin
            chk("contention_alt", 32'(log_id[i+1]), 32'(1 - log_id[i]));
            chk("contention_prod", 32'(log_prod[i]), (log_id[i] == 0) ? 32'd6 : 32'd15);
        end

        // Backpressure: only two results fit while the consumer stalls.
        xfers = 0;
        for (int i = 0; i < 5; i++) cycle(1'b1, 2'b11, 4'h7, 4'h9, 4'hc, 4'hd, 1'b0);
        chk("bp_xfers", 32'(xfers), 32'd2);
        for (int i = 0; i < 4; i++) cycle(1'b1, 2'b11, 4'h7, 4'h9, 4'hc, 4'hd, 1'b1);

        // Reset with both stages full, then the first grant goes to requester 0.
        cycle(1'b1, 2'b11, 4'h1, 4'h2, 4'h3, 4'h4, 1'b0);
        cycle(1'b1, 2'b11, 4'h1, 4'h2, 4'h3, 4'h4, 1'b0);
        cycle(1'b0, 2'b11, 4'h1, 4'h2, 4'h3, 4'h4, 1'b0);
        cycle(1'b1, 2'b11, 4'h1, 4'h2, 4'h3, 4'h4, 1'b1);
        cycle(1'b1, 2'b00, 4'h0, 4'h0, 4'h0, 4'h0, 1'b1);

        // Random traffic with overflow flag exercised and occasional reset.
        ovf_en = 1'b1;
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(0, 49) != 0), 2'($urandom_range(0, 3)),
                  4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom),
                  ($urandom_range(0, 3) != 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
